// File: rtl/pose_sequencer.sv
// pose_sequencer: teach-and-replay sequencer for the five-servo arm.
// Records up to NUM_POSES snapshots of five 8-bit joint positions and replays
// them in order. Each joint ramps one unit per step toward the targeted pose,
// the reached pose is held, then the sequencer advances (optionally looping).
module pose_sequencer #(
  parameter int NUM_POSES  = 8,
  parameter int STEP_TICKS = 500000,
  parameter int HOLD_TICKS = 25000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rec,
  input  logic                         clr,
  input  logic                         play,
  input  logic                         loop,
  input  logic [39:0]                  pos_in,
  output logic [39:0]                  pos_cmd,
  output logic                         cmd_valid,
  output logic [$clog2(NUM_POSES)-1:0] pose_idx,
  output logic [$clog2(NUM_POSES):0]   pose_cnt,
  output logic                         done
);

  localparam int IDX_W     = $clog2(NUM_POSES);
  localparam int MAX_TICKS = (STEP_TICKS > HOLD_TICKS) ? STEP_TICKS : HOLD_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] TICK_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TICK_ZERO = {CNT_W{1'b0}};
  localparam logic [IDX_W:0]   CNT_FULL  = (IDX_W + 1)'(NUM_POSES);
  localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0]   CNT_ZERO  = {(IDX_W + 1){1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [39:0]        pos_cmd_q, pos_cmd_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [IDX_W-1:0]   pose_idx_q, pose_idx_d;
  logic [IDX_W:0]     pose_cnt_q, pose_cnt_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   tick_q, tick_d;

  // Pose table; contents are meaningless until written, so it carries no reset.
  logic [39:0]        slot_q [NUM_POSES];

  logic               wr_en;
  logic [39:0]        target_pose;
  logic               at_target;
  logic               step_fire;
  logic               hold_fire;
  logic               more_poses;

  // Move one channel a single unit toward its target; never wraps because
  // it only increments below the target and only decrements above it.
  function automatic logic [7:0] step_chan(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] res;
    if (cur < tgt) begin
      res = cur + 8'd1;
    end else if (cur > tgt) begin
      res = cur - 8'd1;
    end else begin
      res = cur;
    end
    return res;
  endfunction

  // Apply one ramp step to all five packed channels.
  function automatic logic [39:0] step_pose(input logic [39:0] cur, input logic [39:0] tgt);
    logic [39:0] res;
    res = cur;
    for (int c = 0; c < 5; c++) begin
      res[8*c +: 8] = step_chan(cur[8*c +: 8], tgt[8*c +: 8]);
    end
    return res;
  endfunction

  assign target_pose = slot_q[pose_idx_q];
  assign at_target   = (pos_cmd_q == target_pose);
  assign step_fire   = (tick_q == STEP_LAST);
  assign hold_fire   = (tick_q == HOLD_LAST);
  // pose_idx < pose_cnt-1, written without the subtraction so it cannot underflow
  assign more_poses  = (({1'b0, pose_idx_q} + CNT_ONE) < pose_cnt_q);

  // Next-state, table write and output logic for the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    pos_cmd_d   = pos_cmd_q;
    cmd_valid_d = cmd_valid_q;
    pose_idx_d  = pose_idx_q;
    pose_cnt_d  = pose_cnt_q;
    wr_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_valid_d = 1'b0;
        pos_cmd_d   = pos_in;
        // clr has priority over rec; a full table silently drops rec
        if (clr) begin
          pose_cnt_d = CNT_ZERO;
        end else if (rec && (pose_cnt_q != CNT_FULL)) begin
          wr_en      = 1'b1;
          pose_cnt_d = pose_cnt_q + CNT_ONE;
        end else begin
          pose_cnt_d = pose_cnt_q;
        end
        // Bumpless handover: keep the last manual position as the ramp start
        if (play && (pose_cnt_q != CNT_ZERO)) begin
          state_d     = ST_RAMP;
          pose_idx_d  = IDX_ZERO;
          cmd_valid_d = 1'b1;
          pos_cmd_d   = pos_cmd_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RAMP: begin
        if (!play) begin
          state_d     = ST_IDLE;
          cmd_valid_d = 1'b0;
          pos_cmd_d   = pos_in;
        end else if (at_target) begin
          state_d = ST_HOLD;
        end else if (step_fire) begin
          pos_cmd_d = step_pose(pos_cmd_q, target_pose);
        end else begin
          pos_cmd_d = pos_cmd_q;
        end
      end
      ST_HOLD: begin
        if (!play) begin
          state_d     = ST_IDLE;
          cmd_valid_d = 1'b0;
          pos_cmd_d   = pos_in;
        end else if (hold_fire) begin
          if (more_poses) begin
            state_d    = ST_RAMP;
            pose_idx_d = pose_idx_q + IDX_ONE;
          end else if (loop) begin
            state_d    = ST_RAMP;
            pose_idx_d = IDX_ZERO;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DONE: begin
        // Final pose stays on the servos until the operator releases play
        if (!play) begin
          state_d     = ST_IDLE;
          cmd_valid_d = 1'b0;
          pos_cmd_d   = pos_in;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_valid_d = 1'b0;
        pos_cmd_d   = pos_in;
      end
    endcase
  end

  // Shared step/hold timer, restarted on every state entry, plus done pulse.
  always_comb begin
    tick_d = TICK_ZERO;
    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    if (state_d != state_q) begin
      tick_d = TICK_ZERO;
    end else if ((state_q == ST_RAMP) && step_fire) begin
      tick_d = TICK_ZERO;
    end else if ((state_q == ST_RAMP) || (state_q == ST_HOLD)) begin
      tick_d = tick_q + TICK_ONE;
    end else begin
      tick_d = TICK_ZERO;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pos_cmd_q   <= 40'd0;
      cmd_valid_q <= 1'b0;
      pose_idx_q  <= IDX_ZERO;
      pose_cnt_q  <= CNT_ZERO;
      done_q      <= 1'b0;
      tick_q      <= TICK_ZERO;
    end else begin
      state_q     <= state_d;
      pos_cmd_q   <= pos_cmd_d;
      cmd_valid_q <= cmd_valid_d;
      pose_idx_q  <= pose_idx_d;
      pose_cnt_q  <= pose_cnt_d;
      done_q      <= done_d;
      tick_q      <= tick_d;
    end
  end

  // Pose table write port, addressed by the current pose count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      slot_q[pose_cnt_q[IDX_W-1:0]] <= pos_in;
    end
  end

  assign pos_cmd   = pos_cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign pose_idx  = pose_idx_q;
  assign pose_cnt  = pose_cnt_q;
  assign done      = done_q;

endmodule

// File: doc/pose_sequencer.md
# pose_sequencer

Teach-and-replay sequencer for the five-servo arm. It records up to NUM_POSES snapshots of the five 8-bit joint positions and replays them in order. During replay every joint ramps toward the next pose one position unit per step, then the arm holds the pose before the sequencer advances. It sits between the manual button/servo_controller position path and the servo pulse generators. While cmd_valid is high, the top level drives the servos from pos_cmd instead of the manual positions.

## Interface
- NUM_POSES, 8, pose slots (power of two, 2..16)
- STEP_TICKS, 500000, clk cycles per one-unit ramp step (≥2)
- HOLD_TICKS, 25000000, clk cycles a reached pose is held (≥2)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- rec  in  1  one-cycle debounced pulse; stores pos_in into the next free slot
- clr  in  1  one-cycle pulse; empties the pose table
- play  in  1  level; 1 = replay, 0 = stop and return control
- loop  in  1  level; 1 = wrap to slot 0 after the last pose
- pos_in  in  40  manual positions, ch1 in [7:0] … ch5 in [39:32]
- pos_cmd  out  40  commanded positions, same packing
- cmd_valid  out  1  sequencer owns the servos
- pose_idx  out  log2(NUM_POSES)  slot currently targeted
- pose_cnt  out  log2(NUM_POSES)+1  stored poses, 0..NUM_POSES
- done  out  1  one-cycle pulse at the end of a non-looping replay

## Operation
- States: IDLE, RAMP, HOLD, DONE.
- Reset values: state IDLE; pos_cmd 0; cmd_valid 0; pose_idx 0; pose_cnt 0; done 0. Pose table contents are don't-care.
- IDLE:
  - cmd_valid 0; pos_cmd <= pos_in every cycle.
  - rec with pose_cnt<NUM_POSES writes slot[pose_cnt] and increments pose_cnt. rec when full is ignored.
  - clr sets pose_cnt to 0. If rec and clr arrive in the same cycle, clr wins and nothing is written.
  - play=1 with pose_cnt≠0 moves to RAMP: pose_idx<=0, cmd_valid<=1, pos_cmd keeps its last value (bumpless handover).
  - play=1 with pose_cnt=0 stays in IDLE.
- RAMP:
  - A step counter fires every STEP_TICKS cycles. On each firing, every channel with pos_cmd<target increments by 1 and every channel with pos_cmd>target decrements by 1. Arithmetic is unsigned 8-bit and never wraps.
  - When all five channels equal slot[pose_idx], the next state is HOLD. This check is evaluated every cycle, so a pose already reached goes to HOLD one cycle after RAMP entry.
- HOLD:
  - After HOLD_TICKS cycles:
    - if pose_idx<pose_cnt-1: pose_idx+1, go to RAMP;
    - else if loop=1: pose_idx<=0, go to RAMP;
    - else go to DONE.
- DONE: done=1 for the entry cycle only. cmd_valid stays 1 and pos_cmd holds the final pose. Returns to IDLE once play=0.
- play=0 in RAMP or HOLD returns to IDLE on the next edge, and cmd_valid falls on that same edge.
- rec and clr are ignored outside IDLE.
- The step and hold counters reset on every state entry.
- Asserting rst_n low in any state forces the reset values immediately, without waiting for clk.

## Timing
- All outputs are registered.
- IDLE→RAMP occurs one edge after play is sampled high.
- The first ramp step occurs STEP_TICKS cycles after RAMP entry, then every STEP_TICKS cycles after that.
- A distance of d units takes d·STEP_TICKS cycles from RAMP entry. HOLD is entered on the following edge.
- HOLD lasts exactly HOLD_TICKS cycles.
- A rec write is visible in pose_cnt on the next edge.

## Test plan
Bench parameters: STEP_TICKS=4, HOLD_TICKS=8, NUM_POSES=4.
- Reset and recording: drive rst_n low, then release. All outputs read 0. Send four rec pulses with distinct pos_in values; pose_cnt goes 1,2,3,4. A fifth rec leaves pose_cnt=4 and slots unchanged. rec+clr in the same cycle gives pose_cnt=0.
- Single ramp: pos_in=90 on all channels, slot0 ch1=94, others 90, play=1. ch1 reads 91,92,93,94 at 4,8,12,16 cycles after RAMP entry. HOLD is entered at cycle 17. Other channels stay at 90.
- Sequence end: two poses, loop=0. pose_idx goes 0→1. done pulses for exactly one cycle. cmd_valid stays 1 until play=0, then 0 the cycle after.
- Loop wrap: three poses, loop=1. pose_idx cycles 0,1,2,0,1 with no DONE state.
- Abort and reset: drop play mid-RAMP; cmd_valid is 0 the next cycle and pos_cmd follows pos_in. Pulse rst_n low mid-HOLD; state returns to IDLE with the reset values asynchronously.
- Empty play: pose_cnt=0 with play=1 leaves cmd_valid at 0 for 100 cycles.
